// File: rtl/verdict_gate_pkg.sv
// Shared types for the verdict gate: egress FSM states, buffered beat layout
// and a pointer-width helper.
package verdict_gate_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } gate_state_t;

  localparam int unsigned PKT_DATA_W = 512;
  localparam int unsigned PKT_KEEP_W = PKT_DATA_W / 8;

  typedef struct packed {
    logic [PKT_DATA_W-1:0] data;
    logic [PKT_KEEP_W-1:0] keep;
    logic                  last;
  } pkt_entry_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fwft_fifo.sv
// Synchronous show-ahead FIFO: head word is visible on dout while not empty.
module sync_fwft_fifo
  import verdict_gate_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    push,
  input  logic [WIDTH-1:0]        din,
  input  logic                    pop,
  output logic [WIDTH-1:0]        dout,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   count
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pushes while full are discarded even if a pop happens in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/verdict_gate_ctrl.sv
// Buffers ingress packets until their one-bit verdict arrives, then forwards
// or discards each whole packet and keeps forward/drop statistics.
module verdict_gate_ctrl
  import verdict_gate_pkg::*;
#(
  parameter int unsigned C_BUS_DATA_WIDTH = PKT_DATA_W,
  parameter int unsigned C_BUS_KEEP_WIDTH = C_BUS_DATA_WIDTH / 8,
  parameter int unsigned C_PKT_DEPTH      = 64,
  parameter int unsigned C_VERDICT_DEPTH  = 16,
  parameter bit          C_DROP_ON_MATCH  = 1'b1
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [C_BUS_DATA_WIDTH-1:0] IN_PACKET_TDATA,
  input  logic [C_BUS_KEEP_WIDTH-1:0] IN_PACKET_TKEEP,
  input  logic                        IN_PACKET_TLAST,
  input  logic                        IN_PACKET_TVALID,
  output logic                        IN_PACKET_TREADY,
  input  logic                        RULE_TDATA,
  input  logic                        RULE_TVALID,
  output logic [C_BUS_DATA_WIDTH-1:0] OUT_PACKET_TDATA,
  output logic [C_BUS_KEEP_WIDTH-1:0] OUT_PACKET_TKEEP,
  output logic                        OUT_PACKET_TLAST,
  output logic                        OUT_PACKET_TVALID,
  input  logic                        OUT_PACKET_TREADY,
  output logic [31:0]                 STAT_FWD_CNT,
  output logic [31:0]                 STAT_DROP_CNT,
  output logic                        VERDICT_ERR
);

  localparam int unsigned PKT_W = $bits(pkt_entry_t);
  localparam int unsigned PAW   = clog2(C_PKT_DEPTH);
  localparam int unsigned VAW   = clog2(C_VERDICT_DEPTH);

  gate_state_t state, state_nxt;

  pkt_entry_t  pkt_din, pkt_head;
  logic        pkt_push, pkt_pop, pkt_full, pkt_empty;
  logic [PAW:0] pkt_count;

  logic [0:0]  vq_dout;
  logic        vq_pop, vq_full, vq_empty;
  logic [VAW:0] vq_count;

  logic        sof;
  logic [VAW:0] inflight;
  logic        in_fire;
  logic        out_valid, fwd_done, drop_done;
  logic        unused_status;

  assign unused_status = ^{pkt_count, vq_count};

  assign pkt_din  = '{data: IN_PACKET_TDATA, keep: IN_PACKET_TKEEP, last: IN_PACKET_TLAST};
  assign in_fire  = IN_PACKET_TVALID & IN_PACKET_TREADY;
  assign pkt_push = in_fire;

  // A new packet may only start while a verdict slot is guaranteed for it.
  assign IN_PACKET_TREADY = RST_N & ~pkt_full &
                            ~(sof & (inflight == (VAW+1)'(C_VERDICT_DEPTH)));

  sync_fwft_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (C_PKT_DEPTH)
  ) u_pkt_buf (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (pkt_push),
    .din   (pkt_din),
    .pop   (pkt_pop),
    .dout  (pkt_head),
    .full  (pkt_full),
    .empty (pkt_empty),
    .count (pkt_count)
  );

  sync_fwft_fifo #(
    .WIDTH (1),
    .DEPTH (C_VERDICT_DEPTH)
  ) u_verdict_q (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (RULE_TVALID),
    .din   (RULE_TDATA),
    .pop   (vq_pop),
    .dout  (vq_dout),
    .full  (vq_full),
    .empty (vq_empty),
    .count (vq_count)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= ST_IDLE;
      sof           <= 1'b1;
      inflight      <= '0;
      STAT_FWD_CNT  <= '0;
      STAT_DROP_CNT <= '0;
      VERDICT_ERR   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (in_fire) sof <= IN_PACKET_TLAST;
      if ((in_fire & sof) & ~vq_pop)      inflight <= inflight + 1'b1;
      else if (~(in_fire & sof) & vq_pop) inflight <= inflight - 1'b1;
      if (fwd_done && STAT_FWD_CNT != '1)   STAT_FWD_CNT  <= STAT_FWD_CNT + 1'b1;
      if (drop_done && STAT_DROP_CNT != '1) STAT_DROP_CNT <= STAT_DROP_CNT + 1'b1;
      if (RULE_TVALID && vq_full) VERDICT_ERR <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    vq_pop    = 1'b0;
    pkt_pop   = 1'b0;
    out_valid = 1'b0;
    fwd_done  = 1'b0;
    drop_done = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!vq_empty && !pkt_empty) begin
          vq_pop    = 1'b1;
          state_nxt = (vq_dout[0] == C_DROP_ON_MATCH) ? ST_DROP : ST_FWD;
        end
      end
      ST_FWD: begin
        out_valid = ~pkt_empty;
        pkt_pop   = out_valid & OUT_PACKET_TREADY;
        if (pkt_pop && pkt_head.last) begin
          fwd_done  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_DROP: begin
        pkt_pop = ~pkt_empty;
        if (pkt_pop && pkt_head.last) begin
          drop_done = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The buffer head is undefined while empty, so egress fields are gated to 0.
  assign OUT_PACKET_TVALID = out_valid;
  assign OUT_PACKET_TDATA  = out_valid ? pkt_head.data : '0;
  assign OUT_PACKET_TKEEP  = out_valid ? pkt_head.keep : '0;
  assign OUT_PACKET_TLAST  = out_valid & pkt_head.last;

endmodule

// File: tb/tb_verdict_gate_ctrl.sv
// Scoreboard bench for verdict_gate_ctrl: forwarded beats are queued at send
// time and checked in order as they leave the egress port.
module tb_verdict_gate_ctrl;

  localparam int unsigned DW = 512;
  localparam int unsigned KW = DW / 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [DW-1:0] IN_PACKET_TDATA;
  logic [KW-1:0] IN_PACKET_TKEEP;
  logic          IN_PACKET_TLAST;
  logic          IN_PACKET_TVALID;
  logic          IN_PACKET_TREADY;
  logic          RULE_TDATA;
  logic          RULE_TVALID;
  logic [DW-1:0] OUT_PACKET_TDATA;
  logic [KW-1:0] OUT_PACKET_TKEEP;
  logic          OUT_PACKET_TLAST;
  logic          OUT_PACKET_TVALID;
  logic          OUT_PACKET_TREADY;
  logic [31:0]   STAT_FWD_CNT;
  logic [31:0]   STAT_DROP_CNT;
  logic          VERDICT_ERR;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned beats_out = 0;
  int unsigned exp_fwd  = 0;
  int unsigned exp_drop = 0;
  beat_t       exp_q[$];
  bit          stall_prev = 1'b0;

  verdict_gate_ctrl #(
    .C_BUS_DATA_WIDTH (DW),
    .C_BUS_KEEP_WIDTH (KW),
    .C_PKT_DEPTH      (64),
    .C_VERDICT_DEPTH  (16),
    .C_DROP_ON_MATCH  (1'b1)
  ) dut (
    .CLK               (CLK),
    .RST_N             (RST_N),
    .IN_PACKET_TDATA   (IN_PACKET_TDATA),
    .IN_PACKET_TKEEP   (IN_PACKET_TKEEP),
    .IN_PACKET_TLAST   (IN_PACKET_TLAST),
    .IN_PACKET_TVALID  (IN_PACKET_TVALID),
    .IN_PACKET_TREADY  (IN_PACKET_TREADY),
    .RULE_TDATA        (RULE_TDATA),
    .RULE_TVALID       (RULE_TVALID),
    .OUT_PACKET_TDATA  (OUT_PACKET_TDATA),
    .OUT_PACKET_TKEEP  (OUT_PACKET_TKEEP),
    .OUT_PACKET_TLAST  (OUT_PACKET_TLAST),
    .OUT_PACKET_TVALID (OUT_PACKET_TVALID),
    .OUT_PACKET_TREADY (OUT_PACKET_TREADY),
    .STAT_FWD_CNT      (STAT_FWD_CNT),
    .STAT_DROP_CNT     (STAT_DROP_CNT),
    .VERDICT_ERR       (VERDICT_ERR)
  );

  always #5 CLK = ~CLK;

  // Egress monitor: every handshake must match the head of the scoreboard.
  always @(negedge CLK) begin
    beat_t e;
    if (RST_N && OUT_PACKET_TVALID && OUT_PACKET_TREADY) begin
      beats_out++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: got tlast=%b keep=%h with no beat expected",
                 OUT_PACKET_TLAST, OUT_PACKET_TKEEP);
      end else begin
        e = exp_q.pop_front();
        if ({OUT_PACKET_TDATA, OUT_PACKET_TKEEP, OUT_PACKET_TLAST} !== e) begin
          n_fail++;
          $display("FAIL beat_data: got d=%h k=%h l=%b want d=%h k=%h l=%b",
                   OUT_PACKET_TDATA, OUT_PACKET_TKEEP, OUT_PACKET_TLAST, e.d, e.k, e.l);
        end
      end
    end
    if (RST_N && stall_prev) begin
      n_checks++;
      if (OUT_PACKET_TVALID !== 1'b1) begin
        n_fail++;
        $display("FAIL valid_withdrawn: got tvalid=%b want 1 while stalled", OUT_PACKET_TVALID);
      end
    end
    stall_prev = RST_N && OUT_PACKET_TVALID && !OUT_PACKET_TREADY;
  end

  function automatic beat_t rnd_beat(input logic last);
    beat_t b;
    for (int i = 0; i < int'(DW / 32); i++) b.d[i*32 +: 32] = $urandom();
    b.k = {$urandom(), $urandom()};
    b.l = last;
    return b;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_beat(input beat_t b, input bit fwd);
    bit acc;
    int unsigned t;
    acc = 1'b0;
    t = 0;
    IN_PACKET_TDATA  = b.d;
    IN_PACKET_TKEEP  = b.k;
    IN_PACKET_TLAST  = b.l;
    IN_PACKET_TVALID = 1'b1;
    while (!acc && t < 2000) begin
      @(negedge CLK);
      acc = IN_PACKET_TREADY;
      tick();
      t++;
    end
    IN_PACKET_TVALID = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL ingress_timeout: got tready=0 for %0d cycles want acceptance", t);
    end else if (fwd) begin
      exp_q.push_back(b);
    end
  endtask

  task automatic send_pkt(input int unsigned nbeats, input bit fwd);
    for (int unsigned i = 0; i < nbeats; i++) send_beat(rnd_beat(i == nbeats - 1), fwd);
  endtask

  task automatic send_verdict(input logic v);
    RULE_TDATA  = v;
    RULE_TVALID = 1'b1;
    tick();
    RULE_TVALID = 1'b0;
    RULE_TDATA  = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      tick();
      t++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d beats pending want 0", exp_q.size());
    end
    repeat (8) tick();
  endtask

  task automatic check_stats(input string tag);
    n_checks++;
    if (STAT_FWD_CNT !== exp_fwd) begin
      n_fail++;
      $display("FAIL %s_fwd_cnt: got %0d want %0d", tag, STAT_FWD_CNT, exp_fwd);
    end
    n_checks++;
    if (STAT_DROP_CNT !== exp_drop) begin
      n_fail++;
      $display("FAIL %s_drop_cnt: got %0d want %0d", tag, STAT_DROP_CNT, exp_drop);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    IN_PACKET_TDATA = '0; IN_PACKET_TKEEP = '0; IN_PACKET_TLAST = 1'b0;
    IN_PACKET_TVALID = 1'b0; RULE_TDATA = 1'b0; RULE_TVALID = 1'b0;
    OUT_PACKET_TREADY = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({OUT_PACKET_TVALID, OUT_PACKET_TLAST, OUT_PACKET_TKEEP, OUT_PACKET_TDATA} !== '0) begin
      n_fail++;
      $display("FAIL rst_outputs: got valid=%b last=%b keep=%h want all 0",
               OUT_PACKET_TVALID, OUT_PACKET_TLAST, OUT_PACKET_TKEEP);
    end
    n_checks++;
    if (IN_PACKET_TREADY !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_in_ready: got %b want 0", IN_PACKET_TREADY);
    end
    check_stats("rst");
    n_checks++;
    if (VERDICT_ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_verdict_err: got %b want 0", VERDICT_ERR);
    end
    RST_N = 1'b1;
    tick();
    n_checks++;
    if (IN_PACKET_TREADY !== 1'b1) begin
      n_fail++;
      $display("FAIL post_rst_in_ready: got %b want 1", IN_PACKET_TREADY);
    end
  endtask

  task automatic test_forward();
    int unsigned b0;
    b0 = beats_out;
    send_pkt(3, 1'b1);
    send_verdict(1'b0);
    @(negedge CLK);
    n_checks++;
    if (OUT_PACKET_TVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_latency_early: got tvalid=%b want 0 one cycle after verdict", OUT_PACKET_TVALID);
    end
    @(negedge CLK);
    n_checks++;
    if (OUT_PACKET_TVALID !== 1'b1) begin
      n_fail++;
      $display("FAIL fwd_latency: got tvalid=%b want 1 two cycles after verdict", OUT_PACKET_TVALID);
    end
    #1;
    wait_drain();
    exp_fwd++;
    n_checks++;
    if (beats_out - b0 != 3) begin
      n_fail++;
      $display("FAIL fwd_beats: got %0d want 3", beats_out - b0);
    end
    check_stats("fwd");
  endtask

  task automatic test_drop();
    send_pkt(3, 1'b0);
    send_verdict(1'b1);
    repeat (4) @(negedge CLK);
    n_checks++;
    if (dut.pkt_empty !== 1'b0 || STAT_DROP_CNT !== exp_drop) begin
      n_fail++;
      $display("FAIL drop_midway: got empty=%b drop=%0d want empty=0 drop=%0d",
               dut.pkt_empty, STAT_DROP_CNT, exp_drop);
    end
    @(negedge CLK);
    exp_drop++;
    n_checks++;
    if (dut.pkt_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_empty: got empty=%b want 1 three cycles after verdict pop", dut.pkt_empty);
    end
    #1;
    repeat (8) tick();
    check_stats("drop");
  endtask

  task automatic test_alternating();
    int unsigned b0;
    bit fwd_tbl [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    b0 = beats_out;
    for (int i = 0; i < 4; i++) send_pkt(2, fwd_tbl[i]);
    for (int i = 0; i < 4; i++) send_verdict(~fwd_tbl[i]);
    wait_drain();
    exp_fwd  += 2;
    exp_drop += 2;
    n_checks++;
    if (beats_out - b0 != 4) begin
      n_fail++;
      $display("FAIL alt_beats: got %0d want 4", beats_out - b0);
    end
    check_stats("alt");
  endtask

  task automatic test_backpressure();
    int unsigned b0;
    b0 = beats_out;
    OUT_PACKET_TREADY = 1'b0;
    send_verdict(1'b0);
    for (int unsigned i = 0; i < 64; i++) send_beat(rnd_beat(1'b0), 1'b1);
    repeat (3) begin
      @(negedge CLK);
      n_checks++;
      if (IN_PACKET_TREADY !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_full_ready: got %b want 0 with 64 beats buffered", IN_PACKET_TREADY);
      end
      #1;
    end
    #5;
    fork
      begin
        repeat (4) tick();
        OUT_PACKET_TREADY = 1'b1;
      end
      for (int unsigned i = 64; i < 70; i++) send_beat(rnd_beat(i == 69), 1'b1);
    join
    wait_drain();
    exp_fwd++;
    n_checks++;
    if (beats_out - b0 != 70) begin
      n_fail++;
      $display("FAIL bp_beats: got %0d want 70", beats_out - b0);
    end
    check_stats("bp");
  endtask

  task automatic test_inflight_limit();
    beat_t b17;
    OUT_PACKET_TREADY = 1'b0;
    for (int i = 0; i < 16; i++) send_pkt(1, 1'b1);
    b17 = rnd_beat(1'b1);
    IN_PACKET_TDATA  = b17.d;
    IN_PACKET_TKEEP  = b17.k;
    IN_PACKET_TLAST  = 1'b1;
    IN_PACKET_TVALID = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      n_checks++;
      if (IN_PACKET_TREADY !== 1'b0) begin
        n_fail++;
        $display("FAIL inflight_ready: got %b want 0 on 17th sof beat", IN_PACKET_TREADY);
      end
      #1;
    end
    #5;
    IN_PACKET_TVALID = 1'b0;
    for (int i = 0; i < 16; i++) send_verdict(1'b0);
    send_beat(b17, 1'b1);
    send_verdict(1'b0);
    n_checks++;
    if (VERDICT_ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL inflight_err: got %b want 0", VERDICT_ERR);
    end
    OUT_PACKET_TREADY = 1'b1;
    wait_drain();
    exp_fwd += 17;
    check_stats("inflight");
  endtask

  task automatic test_verdict_err();
    for (int i = 0; i < 16; i++) send_verdict(1'b0);
    n_checks++;
    if (VERDICT_ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL err_at_full: got %b want 0 after 16 verdicts", VERDICT_ERR);
    end
    send_verdict(1'b0);
    n_checks++;
    if (VERDICT_ERR !== 1'b1) begin
      n_fail++;
      $display("FAIL err_overflow: got %b want 1 after 17th verdict", VERDICT_ERR);
    end
    RST_N = 1'b0;
    repeat (2) tick();
    RST_N = 1'b1;
    tick();
    exp_fwd  = 0;
    exp_drop = 0;
    n_checks++;
    if (VERDICT_ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL err_cleared: got %b want 0 after reset", VERDICT_ERR);
    end
  endtask

  task automatic test_reset_mid_fwd();
    beat_t bt [4];
    int unsigned t, b0;
    OUT_PACKET_TREADY = 1'b0;
    for (int i = 0; i < 4; i++) bt[i] = rnd_beat(i == 3);
    for (int i = 0; i < 4; i++) send_beat(bt[i], i == 0);
    send_verdict(1'b0);
    t = 0;
    while (!OUT_PACKET_TVALID && t < 20) begin
      tick();
      t++;
    end
    OUT_PACKET_TREADY = 1'b1;
    tick();
    OUT_PACKET_TREADY = 1'b0;
    RST_N = 1'b0;
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL midrst_first_beat: got %0d pending want 0", exp_q.size());
    end
    n_checks++;
    if ({OUT_PACKET_TVALID, OUT_PACKET_TLAST, OUT_PACKET_TKEEP, OUT_PACKET_TDATA} !== '0 ||
        IN_PACKET_TREADY !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got valid=%b last=%b in_ready=%b want all 0",
               OUT_PACKET_TVALID, OUT_PACKET_TLAST, IN_PACKET_TREADY);
    end
    check_stats("midrst");
    exp_q.delete();
    repeat (3) tick();
    RST_N = 1'b1;
    OUT_PACKET_TREADY = 1'b1;
    tick();
    b0 = beats_out;
    send_pkt(1, 1'b1);
    send_verdict(1'b0);
    wait_drain();
    exp_fwd = 1;
    n_checks++;
    if (beats_out - b0 != 1) begin
      n_fail++;
      $display("FAIL midrst_beats: got %0d want 1", beats_out - b0);
    end
    check_stats("postrst");
  endtask

  initial begin
    test_reset();
    test_forward();
    test_drop();
    test_alternating();
    test_backpressure();
    test_inflight_limit();
    test_verdict_err();
    test_reset_mid_fwd();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/verdict_gate_ctrl.md
Name: verdict_gate_ctrl

Overview:
- Sits downstream of the per-packet rule parser. Stores every ingress packet until the parser's one-bit verdict for that packet arrives.
- Then either forwards the whole packet on the egress AXI4-Stream or silently discards it.
- Sequences the packet buffer and verdict queue so the two stay aligned one-to-one, and keeps forward/drop statistics.

Parameters:
- C_BUS_DATA_WIDTH, 512, stream data width in bits.
- C_BUS_KEEP_WIDTH, C_BUS_DATA_WIDTH/8, TKEEP width.
- C_PKT_DEPTH, 64, packet buffer depth in beats; power of 2, ≥4.
- C_VERDICT_DEPTH, 16, verdict queue depth, which is also the max packets in flight; power of 2, ≥2.
- C_DROP_ON_MATCH, 1, 1: rule=1 drops the packet and rule=0 forwards it; 0: the inverse.

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- IN_PACKET_TDATA  in  C_BUS_DATA_WIDTH  ingress data
- IN_PACKET_TKEEP  in  C_BUS_KEEP_WIDTH  ingress byte enables
- IN_PACKET_TLAST  in  1  ingress end of packet
- IN_PACKET_TVALID  in  1  ingress valid
- IN_PACKET_TREADY  out  1  ingress ready
- RULE_TDATA  in  1  verdict bit, one per packet, in packet order
- RULE_TVALID  in  1  verdict strobe, single cycle, no ready
- OUT_PACKET_TDATA  out  C_BUS_DATA_WIDTH  egress data
- OUT_PACKET_TKEEP  out  C_BUS_KEEP_WIDTH  egress byte enables
- OUT_PACKET_TLAST  out  1  egress end of packet
- OUT_PACKET_TVALID  out  1  egress valid
- OUT_PACKET_TREADY  in  1  egress ready
- STAT_FWD_CNT  out  32  packets forwarded, saturating
- STAT_DROP_CNT  out  32  packets dropped, saturating
- VERDICT_ERR  out  1  sticky; set on RULE_TVALID while the verdict queue is full

Behaviour:
Reset
- Reset is RST_N, asynchronous, active-low; clock is CLK.
- Reset (also mid-packet) flushes both FIFOs, clears the in-flight counter, the sof flag (set to 1), the statistics and VERDICT_ERR, and sets the FSM to IDLE.
- Outputs during reset: all OUT_PACKET_* = 0, IN_PACKET_TREADY = 0.
- Partial packets are lost; no output beat is emitted after reset until a new complete packet plus verdict arrives.

Ingress
- A beat is accepted when TVALID & TREADY.
- IN_PACKET_TREADY = !pkt_full & !(sof & inflight == C_VERDICT_DEPTH).
- sof is set on reset and after an accepted TLAST beat; it is cleared by any other accepted beat.
- inflight increments on an accepted sof beat and decrements on a verdict pop; both in the same cycle leave it unchanged.

Verdict queue
- Push {RULE_TDATA} on RULE_TVALID.
- Full push: the verdict is discarded and VERDICT_ERR is set. This is unreachable when the parser behaves.

Packet buffer
- FWFT FIFO of {TDATA, TKEEP, TLAST}; the head is visible combinationally.
- Simultaneous push and pop when full is not allowed (TREADY is low); when empty, the pushed beat becomes the head next cycle.

Egress FSM
- IDLE: if the verdict queue and the packet buffer are both non-empty, pop the verdict. drop = RULE bit XNOR C_DROP_ON_MATCH... precisely: drop = (bit == C_DROP_ON_MATCH). Go to DROP if drop, else FWD.
- FWD: OUT_TVALID = pkt_not_empty; OUT data = buffer head. Pop on OUT_TVALID & OUT_TREADY. On a popped TLAST beat: STAT_FWD_CNT += 1 and go to IDLE.
- FWD rules: TVALID is never withdrawn while TREADY is low; the buffer running empty mid-packet only deasserts TVALID.
- DROP: OUT_TVALID = 0. Pop one beat per cycle while non-empty, independent of OUT_TREADY. On a popped TLAST beat: STAT_DROP_CNT += 1 and go to IDLE.

Latency and counters
- Verdict pushed in cycle N → queue non-empty N+1 → IDLE pops at N+1 → first egress beat valid at N+2.
- One idle bubble cycle between packets.
- Counters stop at 0xFFFFFFFF.

Decomposition:
- Shared package verdict_gate_pkg holds:
  - the FSM state encoding (IDLE, FWD, DROP);
  - the packet-entry struct {data, keep, last};
  - the function clog2 for pointer widths.
- One sub-module, sync_fwft_fifo, parameterised by width and depth, exposes full, empty, count, and show-ahead dout. It is instantiated twice: packet buffer and verdict queue.

Test Plan:
- 3-beat packet, verdict 0 at the cycle after beat 2, C_DROP_ON_MATCH=1, OUT_TREADY=1 → 3 identical beats out, first at verdict+2; TKEEP/TLAST preserved; STAT_FWD_CNT=1.
- Same packet with verdict 1 → OUT_TVALID never asserts; buffer empty 3 cycles after the verdict pop; STAT_DROP_CNT=1.
- Alternating verdicts 1,0,1,0 on four 2-beat packets → only packets 2 and 4 emerge, in order; FWD=2, DROP=2.
- OUT_TREADY=0 and a 70-beat stream with C_PKT_DEPTH=64 → IN_PACKET_TREADY low after beat 64; release → all 70 beats out, none lost or duplicated.
- 17 single-beat packets, egress stalled, C_VERDICT_DEPTH=16 → TREADY low on the 17th sof beat; VERDICT_ERR stays 0.
- RST_N pulsed low mid-FWD of a 4-beat packet → outputs 0 immediately; a new 1-beat packet with verdict 0 after release is forwarded alone; counters restart from 0.
